// File: rtl/wb_ctrl_pkg.sv
// Shared write-back select encodings, load-queue FSM states and the rd decode helper.
package wb_ctrl_pkg;

  typedef enum logic [1:0] {
    WB_LOAD = 2'b00,
    WB_ALU  = 2'b01,
    WB_PC4  = 2'b10,
    WB_NONE = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    LQ_IDLE = 2'b00,
    LQ_PEND = 2'b01,
    LQ_FULL = 2'b10
  } lq_state_e;

  // x0 is hardwired, so it can never be a hazard.
  function automatic logic [31:0] rd_decode(input logic [4:0] rd);
    logic [31:0] d;
    d = 32'd1 << rd;
    d[0] = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// EX-stage result channel and in-order load-return channel feeding the write-back controller.
interface wb_ctrl_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic [1:0]      ex_sel;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_alu;
  logic [XLEN-1:0] ex_pc_4;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output ex_valid, ex_sel, ex_rd, ex_alu, ex_pc_4, mem_rvalid, mem_rdata,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_sel, ex_rd, ex_alu, ex_pc_4, mem_rvalid, mem_rdata,
    output ex_ready
  );
endinterface

// File: rtl/wb_load_queue.sv
// Outstanding-load FIFO of {rd, live}; kill_all clears live bits but keeps entries so returns still pop.
//  state   | meaning
//  LQ_IDLE | no loads outstanding
//  LQ_PEND | 1 .. LQ_DEPTH-1 loads outstanding
//  LQ_FULL | LQ_DEPTH loads outstanding, further pushes refused
module wb_load_queue import wb_ctrl_pkg::*; #(
  parameter int LQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [4:0]                  push_rd,
  input  logic                        pop,
  input  logic                        kill_all,
  output logic [4:0]                  head_rd,
  output logic                        head_live,
  output logic                        full,
  output logic [$clog2(LQ_DEPTH):0]   count,
  output logic [31:0]                 busy_mask
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;

  lq_state_e         state;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [4:0]        rd_q [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] live_q;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok   = push && (state != LQ_FULL);
  assign pop_ok    = pop && (state != LQ_IDLE);
  assign full      = (state == LQ_FULL);
  assign count     = count_q;
  assign head_rd   = rd_q[rd_ptr];
  assign head_live = live_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LQ_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      live_q  <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) rd_q[i] <= '0;
    end else begin
      if (kill_all) live_q <= '0;
      if (pop_ok) begin
        live_q[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      // Never aliases the head: push is refused when full, pop is refused when empty.
      if (push_ok) begin
        rd_q[wr_ptr]   <= push_rd;
        live_q[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end

      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      case (state)
        LQ_IDLE: if (push_ok) state <= LQ_PEND;
        LQ_PEND: begin
          if (push_ok && !pop_ok && count_q == CW'(LQ_DEPTH - 1)) state <= LQ_FULL;
          else if (pop_ok && !push_ok && count_q == CW'(1))      state <= LQ_IDLE;
        end
        LQ_FULL: if (pop_ok && !push_ok) state <= LQ_PEND;
        default: state <= LQ_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (live_q[i]) busy_mask = busy_mask | rd_decode(rd_q[i]);
    end
  end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back port controller: arbitrates EX results against in-order load returns onto the RF write port.
// Optional build macro WB_STATS_EN adds stall_cnt / wr_cnt performance counters.
module wb_ctrl import wb_ctrl_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_ctrl_if.slave        bus,
  input  logic            flush,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [1:0]      WBSel,
  output logic [XLEN-1:0] wb_alu,
  output logic [XLEN-1:0] wb_dataB,
  output logic [XLEN-1:0] wb_pc_4,
  output logic [31:0]     busy_mask,
  output logic            ld_pending,
  output logic            err_spurious
`ifdef WB_STATS_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     wr_cnt
`endif
);

  logic                      ex_ready_c;
  logic                      acc;
  logic                      is_ex_wb;
  logic                      lq_push;
  logic                      lq_pop;
  logic                      ld_wr;
  logic                      ex_wr;
  logic [4:0]                head_rd;
  logic                      head_live;
  logic                      lq_full;
  logic [$clog2(LQ_DEPTH):0] lq_count;

  assign is_ex_wb = (bus.ex_sel == WB_ALU) || (bus.ex_sel == WB_PC4);

  // Load returns cannot be stalled, so they own the write port and EX results wait.
  always_comb begin
    ex_ready_c = 1'b1;
    case (bus.ex_sel)
      WB_ALU, WB_PC4: ex_ready_c = !bus.mem_rvalid;
      WB_LOAD:        ex_ready_c = !lq_full;
      default:        ex_ready_c = 1'b1;
    endcase
  end

  assign bus.ex_ready = ex_ready_c;
  assign acc          = bus.ex_valid && ex_ready_c && !flush;
  assign lq_push      = acc && (bus.ex_sel == WB_LOAD);
  assign lq_pop       = bus.mem_rvalid && ld_pending;
  assign ld_wr        = lq_pop && head_live && (head_rd != 5'd0) && !flush;
  assign ex_wr        = acc && is_ex_wb && (bus.ex_rd != 5'd0);
  assign ld_pending   = (lq_count != '0);

  wb_load_queue #(.LQ_DEPTH(LQ_DEPTH)) u_lq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lq_push),
    .push_rd   (bus.ex_rd),
    .pop       (lq_pop),
    .kill_all  (flush),
    .head_rd   (head_rd),
    .head_live (head_live),
    .full      (lq_full),
    .count     (lq_count),
    .busy_mask (busy_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      WBSel        <= WB_NONE;
      wb_alu       <= '0;
      wb_dataB     <= '0;
      wb_pc_4      <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (bus.mem_rvalid && !ld_pending) err_spurious <= 1'b1;
      if (ld_wr) begin
        rf_we    <= 1'b1;
        WBSel    <= WB_LOAD;
        rf_waddr <= head_rd;
        wb_dataB <= bus.mem_rdata;
      end else if (ex_wr) begin
        rf_we    <= 1'b1;
        WBSel    <= bus.ex_sel;
        rf_waddr <= bus.ex_rd;
        if (bus.ex_sel == WB_ALU) wb_alu  <= bus.ex_alu;
        else                      wb_pc_4 <= bus.ex_pc_4;
      end else begin
        rf_we <= 1'b0;
        WBSel <= WB_NONE;
      end
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      wr_cnt    <= '0;
    end else begin
      if (bus.ex_valid && !ex_ready_c && !flush) stall_cnt <= stall_cnt + 32'd1;
      if (rf_we) wr_cnt <= wr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed scenarios then random traffic, checked against a queue-based reference model.
module tb_wb_ctrl;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0] rd;
    bit         live;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [1:0] WBSel;
  logic [XLEN-1:0] wb_alu, wb_dataB, wb_pc_4;
  logic [31:0] busy_mask;
  logic ld_pending, err_spurious;
`ifdef WB_STATS_EN
  logic [31:0] stall_cnt, wr_cnt;
`endif

  wb_ctrl_if #(.XLEN(XLEN)) bus ();

  wb_ctrl #(.XLEN(XLEN), .LQ_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .flush        (flush),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .WBSel        (WBSel),
    .wb_alu       (wb_alu),
    .wb_dataB     (wb_dataB),
    .wb_pc_4      (wb_pc_4),
    .busy_mask    (busy_mask),
    .ld_pending   (ld_pending),
    .err_spurious (err_spurious)
`ifdef WB_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .wr_cnt       (wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  ent_t q[$];
  bit          m_we, m_err;
  logic [4:0]  m_waddr;
  logic [1:0]  m_sel;
  logic [31:0] m_alu, m_data, m_pc4;
  int unsigned m_stall, m_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) if (q[i].live) m[q[i].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 0; m_err = 0; m_waddr = '0; m_sel = 2'b11;
    m_alu = '0; m_data = '0; m_pc4 = '0;
    m_stall = 0; m_wr = 0;
  endtask

  task automatic drive(input bit v, input logic [1:0] sel, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input bit rv, input logic [31:0] rdata, input bit fl);
    bus.ex_valid = v; bus.ex_sel = sel; bus.ex_rd = rd;
    bus.ex_alu = alu; bus.ex_pc_4 = pc4;
    bus.mem_rvalid = rv; bus.mem_rdata = rdata; flush = fl;
  endtask

  task automatic idle();
    drive(0, 2'b01, 5'd0, 32'd0, 32'd0, 0, 32'd0, 0);
  endtask

  task automatic check_regs();
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("WBSel", {30'd0, WBSel}, {30'd0, m_sel});
    if (m_we) chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
    chk("wb_alu", wb_alu, m_alu);
    chk("wb_dataB", wb_dataB, m_data);
    chk("wb_pc_4", wb_pc_4, m_pc4);
    chk("err_spurious", {31'd0, err_spurious}, {31'd0, m_err});
`ifdef WB_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("wr_cnt", wr_cnt, m_wr);
`endif
  endtask

  // One clock: inputs are already driven; check combinational outputs, advance model, check registers.
  task automatic cycle();
    bit rdy, acc, nwe;
    ent_t e;
    logic [1:0] sel;
    #1;
    sel = bus.ex_sel;
    if (sel == 2'b01 || sel == 2'b10) rdy = !bus.mem_rvalid;
    else if (sel == 2'b00)            rdy = (q.size() < DEPTH);
    else                              rdy = 1'b1;
    chk("ex_ready", {31'd0, bus.ex_ready}, {31'd0, rdy});
    chk("busy_mask", busy_mask, model_busy());
    chk("ld_pending", {31'd0, ld_pending}, {31'd0, q.size() != 0});

    if (bus.ex_valid && !rdy && !flush) m_stall++;
    if (m_we) m_wr++;
    acc = bus.ex_valid && rdy && !flush;
    nwe = 0;
    if (bus.mem_rvalid) begin
      if (q.size() == 0) m_err = 1;
      else begin
        e = q.pop_front();
        if (e.live && e.rd != 0 && !flush) begin
          nwe = 1; m_sel = 2'b00; m_waddr = e.rd; m_data = bus.mem_rdata;
        end
      end
    end
    if (flush) foreach (q[i]) q[i].live = 0;
    if (acc && sel == 2'b00) begin
      e.rd = bus.ex_rd; e.live = 1; q.push_back(e);
    end
    if (!nwe && acc && (sel == 2'b01 || sel == 2'b10) && bus.ex_rd != 0) begin
      nwe = 1; m_sel = sel; m_waddr = bus.ex_rd;
      if (sel == 2'b01) m_alu = bus.ex_alu; else m_pc4 = bus.ex_pc_4;
    end
    if (!nwe) m_sel = 2'b11;
    m_we = nwe;

    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state and idle with ALU presented but not valid.
    check_regs();
    cycle();
    cycle();

    // ALU rd=5 data 0x1234.
    drive(1, 2'b01, 5'd5, 32'h1234, 32'h0, 0, 32'h0, 0); cycle();
    idle(); cycle();

    // Load rd=7; return collides with ALU rd=3 which must stall one cycle.
    drive(1, 2'b00, 5'd7, 32'h0, 32'h0, 0, 32'h0, 0); cycle();
    drive(1, 2'b01, 5'd3, 32'h33, 32'h0, 1, 32'hCAFE, 0); cycle();
    drive(1, 2'b01, 5'd3, 32'h33, 32'h0, 0, 32'h0, 0); cycle();
    drive(1, 2'b10, 5'd31, 32'h0, 32'h104, 0, 32'h0, 0); cycle();

    // Fill the queue, then a fifth load must stall while ALU still goes through.
    for (int i = 1; i <= 4; i++) begin
      drive(1, 2'b00, 5'(i), 32'h0, 32'h0, 0, 32'h0, 0); cycle();
    end
    drive(1, 2'b00, 5'd9, 32'h0, 32'h0, 0, 32'h0, 0); cycle();
    chk("busy_full", busy_mask, 32'h1E);
    drive(1, 2'b01, 5'd10, 32'hA5A5, 32'h0, 0, 32'h0, 0); cycle();
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'b11, 5'd0, 32'h0, 32'h0, 1, 32'h100 + 32'(i), 0); cycle();
    end

    // Flush kills queued loads; their returns pop without writing; then a spurious return.
    drive(1, 2'b00, 5'd12, 32'h0, 32'h0, 0, 32'h0, 0); cycle();
    drive(1, 2'b00, 5'd13, 32'h0, 32'h0, 0, 32'h0, 0); cycle();
    drive(1, 2'b01, 5'd14, 32'h77, 32'h0, 0, 32'h0, 1); cycle();
    drive(0, 2'b01, 5'd0, 32'h0, 32'h0, 1, 32'hDEAD, 0); cycle();
    drive(0, 2'b01, 5'd0, 32'h0, 32'h0, 1, 32'hBEEF, 0); cycle();
    chk("busy_after_flush", busy_mask, 32'h0);
    drive(0, 2'b01, 5'd0, 32'h0, 32'h0, 1, 32'h5555, 0); cycle();
    chk("err_sticky", {31'd0, err_spurious}, 32'd1);

    // Load to x0 is queued to absorb its return but never written.
    drive(1, 2'b00, 5'd0, 32'h0, 32'h0, 0, 32'h0, 0); cycle();
    drive(0, 2'b00, 5'd0, 32'h0, 32'h0, 1, 32'h9999, 0); cycle();
    idle(); cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      bit rv;
      rv = (q.size() != 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            $urandom, $urandom, rv, $urandom, $urandom_range(0, 19) == 0);
      cycle();
    end

    // Async reset with loads queued; a late return afterwards is spurious.
    drive(1, 2'b00, 5'd21, 32'h0, 32'h0, 0, 32'h0, 0); cycle();
    drive(1, 2'b00, 5'd22, 32'h0, 32'h0, 0, 32'h0, 0); cycle();
    idle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_regs();
    chk("busy_in_reset", busy_mask, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    drive(0, 2'b01, 5'd0, 32'h0, 32'h0, 1, 32'h1111, 0); cycle();
    idle(); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
